// File: rtl/cpu_pkg.sv
// Shared types for the execute-stage condition unit: condition codes, flag indices
// and the registered E-stage control word.
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // flagw[1] enables the N,Z pair; flagw[0] enables the C,V pair.
    typedef struct packed {
        logic       valid;
        cond_e      cond;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       memtoreg;
        logic       alusrc;
        logic [1:0] flagw;
    } e_ctrl_t;

    localparam e_ctrl_t E_BUBBLE = '{
        valid:    1'b0,
        cond:     COND_AL,
        pcs:      1'b0,
        regw:     1'b0,
        memw:     1'b0,
        memtoreg: 1'b0,
        alusrc:   1'b0,
        flagw:    2'b00
    };

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Combinational condition-code evaluator: decides whether an instruction's
// 4-bit condition field passes against the current NZCV flags.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            // NV is reserved and never executes.
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage condition unit: registers the decoded control word, holds NZCV,
// and gates architectural side effects by the evaluated condition.
module cond_exec_stage
    import cpu_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         ALUCTL_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_e,
    input  logic                flush_e,
    input  logic                valid_d,
    input  logic [3:0]          cond_d,
    input  logic                pcs_d,
    input  logic                regw_d,
    input  logic                memw_d,
    input  logic                memtoreg_d,
    input  logic                alusrc_d,
    input  logic [1:0]          flagw_d,
    input  logic [ALUCTL_W-1:0] aluctl_d,
    input  logic [3:0]          alu_flags_e,
    output logic                pcsrc_e,
    output logic                regwrite_e,
    output logic                memwrite_e,
    output logic                memtoreg_e,
    output logic                alusrc_e,
    output logic [ALUCTL_W-1:0] aluctl_e,
    output logic                cond_ex_e,
    output logic [3:0]          flags_q
);

    e_ctrl_t             e_ctrl_d, e_ctrl_q;
    logic [ALUCTL_W-1:0] aluctl_d_nxt, aluctl_q;
    logic [3:0]          flags_d;
    logic                cond_pass;

    // Flush wins over stall so a flushed slot never lingers as a held instruction.
    always_comb begin
        e_ctrl_d     = e_ctrl_q;
        aluctl_d_nxt = aluctl_q;
        if (flush_e) begin
            e_ctrl_d     = E_BUBBLE;
            aluctl_d_nxt = '0;
        end else if (!stall_e) begin
            e_ctrl_d.valid    = valid_d;
            e_ctrl_d.cond     = cond_e'(cond_d);
            e_ctrl_d.pcs      = pcs_d;
            e_ctrl_d.regw     = regw_d;
            e_ctrl_d.memw     = memw_d;
            e_ctrl_d.memtoreg = memtoreg_d;
            e_ctrl_d.alusrc   = alusrc_d;
            e_ctrl_d.flagw    = flagw_d;
            aluctl_d_nxt      = aluctl_d;
        end
    end

    cond_check u_cond_check (
        .cond  (e_ctrl_q.cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    // Gated by stall so a held instruction commits only on the cycle it leaves E.
    assign cond_ex_e  = cond_pass & e_ctrl_q.valid & ~stall_e;
    assign pcsrc_e    = e_ctrl_q.pcs  & cond_ex_e;
    assign regwrite_e = e_ctrl_q.regw & cond_ex_e;
    assign memwrite_e = e_ctrl_q.memw & cond_ex_e;
    assign memtoreg_e = e_ctrl_q.memtoreg;
    assign alusrc_e   = e_ctrl_q.alusrc;
    assign aluctl_e   = aluctl_q;

    always_comb begin
        flags_d = flags_q;
        if (cond_ex_e) begin
            if (e_ctrl_q.flagw[1]) begin
                flags_d[FLAG_N] = alu_flags_e[FLAG_N];
                flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
            end
            if (e_ctrl_q.flagw[0]) begin
                flags_d[FLAG_C] = alu_flags_e[FLAG_C];
                flags_d[FLAG_V] = alu_flags_e[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_ctrl_q <= E_BUBBLE;
            aluctl_q <= '0;
            flags_q  <= RESET_FLAGS;
        end else begin
            e_ctrl_q <= e_ctrl_d;
            aluctl_q <= aluctl_d_nxt;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed scoreboard bench for cond_exec_stage plus an exhaustive sweep of the
// condition evaluator against an independently formulated reference.
module tb_cond_exec_stage;

    logic       clk = 1'b0;
    logic       reset, stall_e, flush_e, valid_d;
    logic [3:0] cond_d;
    logic       pcs_d, regw_d, memw_d, memtoreg_d, alusrc_d;
    logic [1:0] flagw_d;
    logic [3:0] aluctl_d, alu_flags_e;
    logic       pcsrc_e, regwrite_e, memwrite_e, memtoreg_e, alusrc_e, cond_ex_e;
    logic [3:0] aluctl_e, flags_q;

    logic [3:0] sw_cond, sw_flags;
    logic       sw_pass;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic       pc, rw, mw, m2r, as, cx;
        logic [3:0] actl, fl;
    } exp_t;

    exp_t sb[$];
    logic sb_pass[$];

    always #5 clk = ~clk;

    cond_exec_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall_e     (stall_e),
        .flush_e     (flush_e),
        .valid_d     (valid_d),
        .cond_d      (cond_d),
        .pcs_d       (pcs_d),
        .regw_d      (regw_d),
        .memw_d      (memw_d),
        .memtoreg_d  (memtoreg_d),
        .alusrc_d    (alusrc_d),
        .flagw_d     (flagw_d),
        .aluctl_d    (aluctl_d),
        .alu_flags_e (alu_flags_e),
        .pcsrc_e     (pcsrc_e),
        .regwrite_e  (regwrite_e),
        .memwrite_e  (memwrite_e),
        .memtoreg_e  (memtoreg_e),
        .alusrc_e    (alusrc_e),
        .aluctl_e    (aluctl_e),
        .cond_ex_e   (cond_ex_e),
        .flags_q     (flags_q)
    );

    cond_check u_chk (
        .cond  (sw_cond),
        .flags (sw_flags),
        .pass  (sw_pass)
    );

    // Reference written in the base-condition/invert form rather than a 16-way table.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? ~base : base;
    endfunction

    task automatic chk(input string tag, input string field, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic [3:0] c, input logic pcs, input logic rw,
                         input logic mw, input logic m2r, input logic as,
                         input logic [1:0] fw, input logic [3:0] actl);
        valid_d = v; cond_d = c; pcs_d = pcs; regw_d = rw; memw_d = mw;
        memtoreg_d = m2r; alusrc_d = as; flagw_d = fw; aluctl_d = actl;
    endtask

    task automatic set_ctl(input logic rst, input logic stl, input logic fl, input logic [3:0] alu);
        reset = rst; stall_e = stl; flush_e = fl; alu_flags_e = alu;
    endtask

    task automatic expect_out(input string tag, input logic pc, input logic rw, input logic mw,
                              input logic m2r, input logic as, input logic [3:0] actl,
                              input logic cx, input logic [3:0] fl);
        exp_t e;
        e.tag = tag; e.pc = pc; e.rw = rw; e.mw = mw; e.m2r = m2r; e.as = as;
        e.actl = actl; e.cx = cx; e.fl = fl;
        sb.push_back(e);
    endtask

    // Checks this cycle's outputs against the oldest expectation, then advances one edge.
    task automatic check_and_tick();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard", "empty", 4'h1, 4'h0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, "pcsrc_e",    {3'b000, pcsrc_e},    {3'b000, e.pc});
            chk(e.tag, "regwrite_e", {3'b000, regwrite_e}, {3'b000, e.rw});
            chk(e.tag, "memwrite_e", {3'b000, memwrite_e}, {3'b000, e.mw});
            chk(e.tag, "memtoreg_e", {3'b000, memtoreg_e}, {3'b000, e.m2r});
            chk(e.tag, "alusrc_e",   {3'b000, alusrc_e},   {3'b000, e.as});
            chk(e.tag, "aluctl_e",   aluctl_e,             e.actl);
            chk(e.tag, "cond_ex_e",  {3'b000, cond_ex_e},  {3'b000, e.cx});
            chk(e.tag, "flags_q",    flags_q,              e.fl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop_d();
        set_d(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    endtask

    initial begin
        sw_cond = 4'h0; sw_flags = 4'h0;
        set_ctl(1'b1, 1'b0, 1'b0, 4'h0);
        nop_d();
        @(posedge clk);
        #1;

        // Second reset cycle: E holds a bubble, flags at reset value.
        set_ctl(1'b1, 1'b0, 1'b0, 4'h0);
        expect_out("reset", 0, 0, 0, 0, 0, 4'h0, 0, 4'b0000);
        check_and_tick();

        // SUBS enters decode.
        set_ctl(1'b0, 1'b0, 1'b0, 4'h0);
        set_d(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 4'h1);
        expect_out("post_reset", 0, 0, 0, 0, 0, 4'h0, 0, 4'b0000);
        check_and_tick();

        // SUBS in E producing Z; BEQ in decode.
        set_ctl(1'b0, 1'b0, 1'b0, 4'b0100);
        set_d(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
        expect_out("subs_e", 0, 1, 0, 0, 1, 4'h1, 1, 4'b0000);
        check_and_tick();

        // BEQ in E sees Z from SUBS without a bubble; its own ALU flags must not land.
        set_ctl(1'b0, 1'b0, 1'b0, 4'b1111);
        set_d(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'h2);
        expect_out("beq_taken", 1, 0, 0, 0, 0, 4'h0, 1, 4'b0100);
        check_and_tick();

        // CMP clears all flags; ADDEQ in decode.
        set_ctl(1'b0, 1'b0, 1'b0, 4'b0000);
        set_d(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'h0);
        expect_out("cmp_e", 0, 0, 0, 0, 0, 4'h2, 1, 4'b0100);
        check_and_tick();

        // ADDEQ with Z=0 fails: no regwrite and its flags 1001 are dropped.
        set_ctl(1'b0, 1'b0, 1'b0, 4'b1001);
        set_d(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'h3);
        expect_out("addeq_fail", 0, 0, 0, 0, 0, 4'h0, 0, 4'b0000);
        check_and_tick();

        // ANDS writes only N,Z; STR in decode.
        set_ctl(1'b0, 1'b0, 1'b0, 4'b1111);
        set_d(1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'h0);
        expect_out("ands_e", 0, 1, 0, 0, 0, 4'h3, 1, 4'b0000);
        check_and_tick();

        // STR held in E for three stall cycles.
        nop_d();
        for (int i = 0; i < 3; i++) begin
            set_ctl(1'b0, 1'b1, 1'b0, 4'b0011);
            expect_out("str_stall", 0, 0, 0, 0, 1, 4'h0, 0, 4'b1100);
            check_and_tick();
        end

        set_ctl(1'b0, 1'b0, 1'b0, 4'b0011);
        expect_out("str_release", 0, 0, 1, 0, 1, 4'h0, 1, 4'b1100);
        check_and_tick();

        // LDR-like word in decode; STR must have left.
        set_ctl(1'b0, 1'b0, 1'b0, 4'b0000);
        set_d(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'hA);
        expect_out("str_once", 0, 0, 0, 0, 0, 4'h0, 0, 4'b1100);
        check_and_tick();

        // LDR in E with flush and stall together; decode slot contents must be discarded.
        set_ctl(1'b0, 1'b1, 1'b1, 4'b0000);
        set_d(1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 4'h7);
        expect_out("ldr_stall", 0, 0, 0, 1, 1, 4'hA, 0, 4'b1100);
        check_and_tick();

        // ADDS in decode; E holds the bubble from the flush.
        set_ctl(1'b0, 1'b0, 1'b0, 4'b0000);
        set_d(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'h0);
        expect_out("flush_bubble", 0, 0, 0, 0, 0, 4'h0, 0, 4'b1100);
        check_and_tick();

        // ADDS in E while reset asserts: its flags 1111 must not land.
        set_ctl(1'b1, 1'b0, 1'b0, 4'b1111);
        nop_d();
        expect_out("adds_e", 0, 1, 0, 0, 0, 4'h0, 1, 4'b1100);
        check_and_tick();

        set_ctl(1'b0, 1'b0, 1'b0, 4'b0000);
        expect_out("reset_mid", 0, 0, 0, 0, 0, 4'h0, 0, 4'b0000);
        check_and_tick();

        // Exhaustive condition sweep.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                logic [31:0] cv, fv;
                logic        e;
                cv = c; fv = f;
                sw_cond  = cv[3:0];
                sw_flags = fv[3:0];
                sb_pass.push_back(ref_pass(cv[3:0], fv[3:0]));
                #1;
                e = sb_pass.pop_front();
                n_assert++;
                assert (sw_pass === e) else begin
                    n_fail++;
                    $error("FAIL cond_sweep cond=%h flags=%h observed=%b expected=%b",
                           sw_cond, sw_flags, sw_pass, e);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
